// File: rtl/mul_pkg.sv
// Shared constants, ID-width helper and result entry type for the shared
// multiplier arbiter and its requesters.
package mul_pkg;

  localparam int MUL_WIDTH   = 48;
  localparam int MUL_LATENCY = 3;  // must track the external multiplier's stage count
  localparam int MUL_NREQ    = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [id_width(MUL_NREQ)-1:0] id;
    logic [2*MUL_WIDTH-1:0]        product;
  } res_entry_t;

endpackage

// File: rtl/mul_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count; simultaneous
// write and pop are legal at any occupancy, including full.
module mul_result_fifo #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_pop;

  assign valid  = (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = rd_en && valid;
  // Head is forced to zero when empty so the unreset storage never leaks out.
  assign rd_data = valid ? mem[rd_ptr] : '0;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_en, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the count alone decides what is valid, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && full && !do_pop));

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one external pipelined multiplier among
// NREQ requesters, with an ID tag pipeline and credit-protected result FIFO.
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter  int WIDTH      = MUL_WIDTH,
  parameter  int NREQ       = MUL_NREQ,
  parameter  int MUL_LAT    = MUL_LATENCY,
  parameter  int FIFO_DEPTH = 8,
  localparam int IDW        = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_y,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*WIDTH-1:0]    res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0]     id;
    logic [2*WIDTH-1:0] product;
  } entry_t;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_found;
  logic             credit_ok;
  logic             issue;
  logic [CW-1:0]    in_flight;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit_used;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [MUL_LAT-1:0] tag_valid;
  logic [IDW-1:0]   tag_id [MUL_LAT];
  logic             fifo_wr;
  entry_t           wr_entry;
  entry_t           head;

  // Registered counts only, so a pop frees its credit one cycle later and
  // req_ready has no path from res_ready.
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);
  assign issue       = gnt_found && credit_ok;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[IDW'((int'(rr_ptr) + k) % NREQ)]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign fifo_wr  = tag_valid[MUL_LAT-1];
  assign wr_entry = '{id: tag_id[MUL_LAT-1], product: mul_y};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      tag_valid <= '0;
      in_flight <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_id[s] <= '0;
    end else begin
      if (issue) begin
        rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        mul_a  <= sel_a;
        mul_b  <= sel_b;
      end
      // Tags shift unconditionally because the multiplier never stalls.
      tag_valid[0] <= issue;
      tag_id[0]    <= gnt_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
      case ({issue, fifo_wr})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  mul_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (res_ready),
    .rd_data (head),
    .valid   (res_valid),
    .count   (fifo_count)
  );

  assign res_data = head.product;
  assign res_id   = head.id;
  assign busy     = (in_flight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with a behavioural
// fixed-latency multiplier standing in for the external instance.
module tb_mul_share_arbiter;

  localparam int W   = 48;
  localparam int N   = 4;
  localparam int L   = 3;
  localparam int D   = 8;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_a;
  logic [N*W-1:0]     req_b;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic [2*W-1:0]     mul_y;
  logic               res_valid;
  logic               res_ready;
  logic [2*W-1:0]     res_data;
  logic [IDW-1:0]     res_id;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .WIDTH (W), .NREQ (N), .MUL_LAT (L), .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_y     (mul_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  // External multiplier: operands registered by the DUT plus L-1 stages here.
  logic [2*W-1:0] mpipe [L-1];
  always @(posedge clk) begin
    mpipe[0] <= (2*W)'(mul_a) * (2*W)'(mul_b);
    for (int s = 1; s < L - 1; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_y = mpipe[L-2];

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_valid = '0;
    res_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '0;
    res_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
    checks++; if (mul_a !== '0 || mul_b !== '0) begin errors++; $display("FAIL reset_mul_ops got %h/%h want 0/0", mul_a, mul_b); end
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy got %b/%b want 0/0", res_valid, busy); end
    checks++; if (res_data !== '0 || res_id !== '0) begin errors++; $display("FAIL reset_res got %h/%h want 0/0", res_data, res_id); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_op(0, 48'd3, 48'd5);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", req_ready); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_wait cycle %0d valid/busy got %b/%b want 0/1", c, res_valid, busy); end
      if (c == 1) begin
        checks++; if (mul_a !== 48'd3 || mul_b !== 48'd5) begin errors++; $display("FAIL single_mul_ops got %0d/%0d want 3/5", mul_a, mul_b); end
      end
    end
    @(negedge clk);
    #1;
    checks++; if (res_valid !== 1'b1 || res_data !== 96'd15 || res_id !== 2'd0) begin errors++; $display("FAIL single_result got v=%b d=%0d id=%0d want v=1 d=15 id=0", res_valid, res_data, res_id); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drained valid/busy got %b/%b want 0/0", res_valid, busy); end
  endtask

  task automatic test_max();
    int lat;
    @(negedge clk);
    set_op(2, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL max_grant got %b want 0100", req_ready); end
    lat = 0;
    while (!res_valid && lat < 8) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      lat++;
    end
    checks++; if (res_valid !== 1'b1 || lat != 4) begin errors++; $display("FAIL max_latency got valid=%b after %0d cycles want 1 after 4", res_valid, lat); end
    checks++; if (res_data !== 96'hFFFF_FFFF_FFFE_0000_0000_0001 || res_id !== 2'd2) begin errors++; $display("FAIL max_result got %h id %0d want fffffffffffe000000000001 id 2", res_data, res_id); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0]   exp_rdy;
    logic [2*W-1:0] exp_data;
    int             id;
    apply_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(100 + i), 48'd2);
    res_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = (c < 12) ? 4'hF : 4'h0;
      #1;
      if (c < 12) begin
        exp_rdy = 4'b0001 << (c % 4);
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant cycle %0d got %b want %b", c, req_ready, exp_rdy); end
      end
      if (c >= 4 && c < 16) begin
        id = (c - 4) % 4;
        exp_data = (2*W)'(200 + 2 * id);
        checks++; if (res_valid !== 1'b1 || res_id !== IDW'(id) || res_data !== exp_data) begin errors++; $display("FAIL rr_result cycle %0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d", c, res_valid, res_id, res_data, id, exp_data); end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_idle cycle %0d res_valid got %b want 0", c, res_valid); end
      end
    end
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]   exp_rdy;
    logic [2*W-1:0] exp_data;
    int             issued;
    int             exp_id;
    int             got;
    apply_reset();
    res_ready = 1'b0;
    issued = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL bp_grant cycle %0d got %b want %b", c, req_ready, exp_rdy); end
      if (req_ready != '0) issued++;
    end
    checks++; if (issued != D) begin errors++; $display("FAIL bp_issue_count got %0d want %0d", issued, D); end
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 96'd200 || busy !== 1'b1) begin errors++; $display("FAIL bp_full_head got v=%b id=%0d d=%0d busy=%b want v=1 id=0 d=200 busy=1", res_valid, res_id, res_data, busy); end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_pop_no_credit got %b want 0000", req_ready); end
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_credit_grant got %b want 0001", req_ready); end
    checks++; if (res_id !== 2'd1 || res_data !== 96'd202) begin errors++; $display("FAIL bp_new_head got id=%0d d=%0d want id=1 d=202", res_id, res_data); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_regrant got %b want 0000", req_ready); end
    // Drain while new ops keep arriving: writes and pops overlap near full.
    exp_id = 1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      req_valid = (c < 16) ? 4'hF : 4'h0;
      res_ready = 1'b1;
      #1;
      if (res_valid) begin
        exp_data = (2*W)'(200 + 2 * exp_id);
        checks++; if (res_id !== IDW'(exp_id) || res_data !== exp_data) begin errors++; $display("FAIL bp_order result %0d got id=%0d d=%0d want id=%0d d=%0d", got, res_id, res_data, exp_id, exp_data); end
        exp_id = (exp_id + 1) % 4;
        got++;
      end
    end
    checks++; if (got != 23) begin errors++; $display("FAIL bp_drain_count got %0d want 23", got); end
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drained valid/busy got %b/%b want 0/0", res_valid, busy); end
    res_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int lat;
    apply_reset();
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 4'hF;
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mr_loaded valid/busy got %b/%b want 1/1", res_valid, busy); end
    rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== '0 || res_id !== '0) begin errors++; $display("FAIL mr_async_clear got v=%b busy=%b d=%h id=%0d want all 0", res_valid, busy, res_data, res_id); end
    checks++; if (mul_a !== '0 || mul_b !== '0 || req_ready !== '0) begin errors++; $display("FAIL mr_async_ops got %h/%h rdy=%b want 0/0/0000", mul_a, mul_b, req_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mr_stale cycle %0d valid/busy got %b/%b want 0/0", c, res_valid, busy); end
    end
    @(negedge clk);
    set_op(1, 48'd7, 48'd6);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mr_grant got %b want 0010", req_ready); end
    lat = 0;
    while (!res_valid && lat < 8) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      lat++;
    end
    checks++; if (res_valid !== 1'b1 || lat != 4 || res_data !== 96'd42 || res_id !== 2'd1) begin errors++; $display("FAIL mr_result got v=%b lat=%0d d=%0d id=%0d want v=1 lat=4 d=42 id=1", res_valid, lat, res_data, res_id); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_round_robin();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
